// File: rtl/multiply_tokens.sv
// Serial token multiplier: each input token on a owes FACTOR output tokens on b,
// tracked in a saturating pending counter that drains one token per cycle.
module multiply_tokens #(
    parameter int unsigned FACTOR = 2,
    parameter int unsigned CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    output logic             b,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam int unsigned     SW   = CNT_W + 4;
    localparam logic [SW-1:0]   PMAX = SW'((32'd1 << CNT_W) - 32'd1);

    generate
        if (FACTOR < 1 || FACTOR > 8) begin : g_bad_factor
            $error("multiply_tokens: FACTOR must be in 1..8");
        end
        if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
            $error("multiply_tokens: CNT_W must be in 2..16");
        end
    endgenerate

    logic [CNT_W-1:0] r_p;
    logic             r_ovf;
    logic             w_b;
    logic [SW-1:0]    w_sum;

    // The subtraction never underflows: b=1 with a=0 implies P>=1.
    always_comb begin
        w_b   = !rst && (a || (r_p != '0));
        w_sum = SW'(r_p) + (a ? SW'(FACTOR) : '0) - (w_b ? SW'(1) : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p   <= '0;
            r_ovf <= 1'b0;
        end else if (w_sum > PMAX) begin
            r_p   <= PMAX[CNT_W-1:0];
            r_ovf <= 1'b1;
        end else begin
            r_p   <= w_sum[CNT_W-1:0];
        end
    end

    assign b        = w_b;
    assign pending  = r_p;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_multiply_tokens.sv
// Bench for multiply_tokens: four configurations checked against a reference
// model through a scoreboard, plus fixed sequences for the documented cases.
module tb_multiply_tokens;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance 0: F2/W4, 1: F2/W3, 2: F3/W4, 3: F1/W4
    logic       a_i   [4];
    logic       rst_i [4];
    logic       b_o   [4];
    logic       ovf_o [4];
    logic [3:0] p0, p2, p3;
    logic [2:0] p1;

    int unsigned errors = 0;
    int unsigned checks = 0;

    int unsigned factor [4] = '{2, 2, 3, 1};
    int          pmax   [4] = '{15, 7, 15, 15};
    int          mp     [4];
    bit          movf   [4];
    bit          q_b    [$];

    multiply_tokens #(.FACTOR(2), .CNT_W(4)) u_f2 (
        .clk(clk), .rst(rst_i[0]), .a(a_i[0]), .b(b_o[0]), .pending(p0), .overflow(ovf_o[0]));
    multiply_tokens #(.FACTOR(2), .CNT_W(3)) u_f2w3 (
        .clk(clk), .rst(rst_i[1]), .a(a_i[1]), .b(b_o[1]), .pending(p1), .overflow(ovf_o[1]));
    multiply_tokens #(.FACTOR(3), .CNT_W(4)) u_f3 (
        .clk(clk), .rst(rst_i[2]), .a(a_i[2]), .b(b_o[2]), .pending(p2), .overflow(ovf_o[2]));
    multiply_tokens #(.FACTOR(1), .CNT_W(4)) u_f1 (
        .clk(clk), .rst(rst_i[3]), .a(a_i[3]), .b(b_o[3]), .pending(p3), .overflow(ovf_o[3]));

    function automatic int get_p(input int d);
        case (d)
            0:       return int'(p0);
            1:       return int'(p1);
            2:       return int'(p2);
            default: return int'(p3);
        endcase
    endfunction

    // One cycle on instance d (others idle); scoreboard checks b before the
    // edge and pending/overflow after it. Returns the observed values.
    task automatic step(input int d, input bit av, input bit rv,
                        output bit ob, output int op, output bit oo);
        bit eb [4];
        bit exp_b;
        int s;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            a_i[k]   = (k == d) ? av : 1'b0;
            rst_i[k] = (k == d) ? rv : 1'b0;
            eb[k]    = !rst_i[k] && (a_i[k] || (mp[k] != 0));
        end
        q_b.push_back(eb[d]);
        #1;
        exp_b = q_b.pop_front();
        ob = b_o[d];
        checks++;
        if (ob !== exp_b) begin
            errors++;
            $display("FAIL sb_b inst=%0d t=%0t got=%b exp=%b", d, $time, ob, exp_b);
        end
        for (int k = 0; k < 4; k++) begin
            if (rst_i[k]) begin
                mp[k]   = 0;
                movf[k] = 1'b0;
            end else begin
                s = mp[k] + (a_i[k] ? int'(factor[k]) : 0) - (eb[k] ? 1 : 0);
                if (s > pmax[k]) begin
                    mp[k]   = pmax[k];
                    movf[k] = 1'b1;
                end else begin
                    mp[k] = s;
                end
            end
        end
        @(posedge clk);
        #1;
        op = get_p(d);
        oo = ovf_o[d];
        checks++;
        if (op != mp[d] || oo !== movf[d]) begin
            errors++;
            $display("FAIL sb_state inst=%0d t=%0t pending=%0d ovf=%b exp pending=%0d ovf=%b",
                     d, $time, op, oo, mp[d], movf[d]);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            rst_i[k] = 1'b1;
            a_i[k]   = 1'b1;
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (b_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_b inst=%0d got=%b exp=0", k, b_o[k]);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            mp[k] = 0;
            movf[k] = 1'b0;
            checks++;
            if (get_p(k) != 0 || ovf_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state inst=%0d pending=%0d ovf=%b exp 0/0", k, get_p(k), ovf_o[k]);
            end
        end
    endtask

    task automatic test_burst();
        bit ob, oo; int op;
        bit av [6] = '{1, 1, 0, 0, 0, 0};
        bit eb [6] = '{1, 1, 1, 1, 0, 0};
        int ep [6] = '{1, 2, 1, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            step(0, av[i], 1'b0, ob, op, oo);
            checks++;
            if (ob !== eb[i] || op != ep[i]) begin
                errors++;
                $display("FAIL burst[%0d] b=%b pending=%0d exp b=%b pending=%0d", i, ob, op, eb[i], ep[i]);
            end
        end
    endtask

    task automatic test_alternate();
        bit ob, oo; int op;
        for (int i = 0; i < 6; i++) begin
            step(0, (i % 2) == 0, 1'b0, ob, op, oo);
            checks++;
            if (ob !== 1'b1 || op > 1 || oo !== 1'b0) begin
                errors++;
                $display("FAIL alternate[%0d] b=%b pending=%0d ovf=%b exp b=1 pending<=1 ovf=0", i, ob, op, oo);
            end
        end
    endtask

    task automatic test_saturate();
        bit ob, oo; int op;
        step(1, 1'b0, 1'b1, ob, op, oo);
        for (int i = 1; i <= 10; i++) begin
            step(1, 1'b1, 1'b0, ob, op, oo);
            checks++;
            if (op != ((i < 7) ? i : 7) || oo !== (i >= 8)) begin
                errors++;
                $display("FAIL saturate[%0d] pending=%0d ovf=%b exp pending=%0d ovf=%b",
                         i, op, oo, (i < 7) ? i : 7, i >= 8);
            end
        end
        for (int i = 0; i < 9; i++) begin
            step(1, 1'b0, 1'b0, ob, op, oo);
            checks++;
            if (ob !== (i < 7) || oo !== 1'b1) begin
                errors++;
                $display("FAIL drain[%0d] b=%b ovf=%b exp b=%b ovf=1", i, ob, oo, i < 7);
            end
        end
    endtask

    task automatic test_factor3();
        bit ob, oo; int op;
        bit eb [4] = '{1, 1, 1, 0};
        int ep [4] = '{2, 1, 0, 0};
        for (int i = 0; i < 4; i++) begin
            step(2, i == 0, 1'b0, ob, op, oo);
            checks++;
            if (ob !== eb[i] || op != ep[i]) begin
                errors++;
                $display("FAIL factor3[%0d] b=%b pending=%0d exp b=%b pending=%0d", i, ob, op, eb[i], ep[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ob, oo; int op;
        step(0, 1'b0, 1'b1, ob, op, oo);
        for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, ob, op, oo);
        checks++;
        if (op != 3) begin
            errors++;
            $display("FAIL midrst_pre pending=%0d exp=3", op);
        end
        step(0, 1'b1, 1'b1, ob, op, oo);
        checks++;
        if (ob !== 1'b0 || op != 0 || oo !== 1'b0) begin
            errors++;
            $display("FAIL midrst b=%b pending=%0d ovf=%b exp 0/0/0", ob, op, oo);
        end
        step(0, 1'b0, 1'b0, ob, op, oo);
        checks++;
        if (ob !== 1'b0 || op != 0) begin
            errors++;
            $display("FAIL midrst_post b=%b pending=%0d exp 0/0", ob, op);
        end
    endtask

    task automatic test_factor1_random();
        bit ob, oo, av; int op;
        int unsigned bad = 0;
        step(3, 1'b0, 1'b1, ob, op, oo);
        for (int i = 0; i < 1000; i++) begin
            av = 1'($urandom_range(0, 1));
            step(3, av, 1'b0, ob, op, oo);
            if (ob !== av || op != 0 || oo !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL factor1 cycles_wrong=%0d exp=0", bad);
        end
    endtask

    task automatic test_conservation(input int unsigned pct);
        bit ob, oo, av; int op;
        int unsigned na = 0, nb = 0, n = 0;
        step(0, 1'b0, 1'b1, ob, op, oo);
        for (int i = 0; i < 400; i++) begin
            av = ($urandom_range(0, 99) < pct);
            step(0, av, 1'b0, ob, op, oo);
            na += av;
            nb += ob;
        end
        while (op != 0 && n < 40) begin
            step(0, 1'b0, 1'b0, ob, op, oo);
            nb += ob;
            n++;
        end
        checks++;
        if (op != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d exp=0", op);
        end
        checks++;
        if (!movf[0] && nb != 2 * na) begin
            errors++;
            $display("FAIL conservation b_tokens=%0d exp=%0d", nb, 2 * na);
        end else if (movf[0] && nb >= 2 * na) begin
            errors++;
            $display("FAIL overflow_loss b_tokens=%0d exp < %0d", nb, 2 * na);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            a_i[k] = 1'b0;
            rst_i[k] = 1'b0;
            mp[k] = 0;
            movf[k] = 1'b0;
        end
        test_reset();
        test_burst();
        test_alternate();
        test_saturate();
        test_factor3();
        test_reset_mid_burst();
        test_factor1_random();
        test_conservation(30);
        test_conservation(70);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
